// File: rtl/ydp_pkg.sv
// Shared definitions for the ydp control sequencer: opcodes, ALU op codes,
// FSM state encoding and the decoded-control bundle.
package ydp_pkg;

  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_LD = 7'h03;
  localparam logic [6:0] OP_S  = 7'h23;
  localparam logic [6:0] OP_SB = 7'h63;
  localparam logic [6:0] OP_UJ = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/ydp_ctrl_decode.sv
// Combinational opcode/funct decode into the datapath control bundle.
// Unknown opcodes clear 'legal' and leave every write enable low.
module ydp_ctrl_decode
  import ydp_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '{reg_write: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD, mem_write: 1'b0, legal: 1'b1};
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl.alu_op = ALU_AND;
          3'b110:  ctrl.alu_op = ALU_OR;
          3'b010:  ctrl.alu_op = ALU_SLT;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_I, OP_LD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_S: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_SB:   ctrl.alu_op = ALU_SUB;
      OP_UJ:   ctrl.reg_write = 1'b1;
      default: ctrl.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ydp_sequencer.sv
// Four-clock-per-instruction control sequencer owning the PC register.
// Define YDP_BRANCH_EN to follow beq/jal targets; otherwise flow is straight-line.
module ydp_sequencer
  import ydp_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0028,
  parameter logic [15:0] MAX_INSNS = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic [31:0] pcp4,
  input  logic [31:0] branch,
  input  logic [31:0] jtarget,
  input  logic        zero,
  output logic [31:0] pc_in,
  output logic        reg_write,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_write,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired,
  output logic [2:0]  dbg_state
);

  state_t      state;
  ctrl_t       dec;
  logic        rw_q;
  logic        mw_q;
  logic [31:0] next_pc;
  logic [15:0] retired_inc;

  ydp_ctrl_decode u_decode (
    .opcode   (ins[6:0]),
    .funct3   (ins[14:12]),
    .funct7_5 (ins[30]),
    .ctrl     (dec)
  );

  logic unused_ins;
  assign unused_ins  = &{1'b0, ins[31], ins[29:15], ins[11:7]};
  assign dbg_state   = state;
  assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;

`ifdef YDP_BRANCH_EN
  logic is_sb_q;
  logic is_uj_q;
  logic zero_q;

  always_comb begin
    next_pc = pcp4;
    if (is_uj_q)                next_pc = jtarget;
    else if (is_sb_q && zero_q) next_pc = branch;
  end

  // Branch-type flags latched in DECODE, zero latched at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_sb_q <= 1'b0;
      is_uj_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (state == ST_DECODE) begin
        is_sb_q <= (ins[6:0] == OP_SB);
        is_uj_q <= (ins[6:0] == OP_UJ);
      end
      if (state == ST_EXEC) zero_q <= zero;
    end
  end
`else
  logic unused_branch;
  assign unused_branch = &{1'b0, branch, jtarget, zero};
  assign next_pc       = pcp4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc_in     <= RESET_PC;
      reg_write <= 1'b0;
      alu_src   <= 1'b0;
      alu_op    <= ALU_ADD;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      retired   <= 16'd0;
      rw_q      <= 1'b0;
      mw_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state   <= ST_FETCH;
            pc_in   <= RESET_PC;
            retired <= 16'd0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (dec.legal) begin
            state   <= ST_EXEC;
            alu_src <= dec.alu_src;
            alu_op  <= dec.alu_op;
            rw_q    <= dec.reg_write;
            mw_q    <= dec.mem_write;
          end else begin
            state   <= ST_HALT;
            illegal <= 1'b1;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end
        end
        ST_EXEC: begin
          state     <= ST_WB;
          reg_write <= rw_q;
          mem_write <= mw_q;
        end
        ST_WB: begin
          reg_write <= 1'b0;
          mem_write <= 1'b0;
          pc_in     <= next_pc;
          retired   <= retired_inc;
          if (MAX_INSNS != 16'd0 && retired_inc == MAX_INSNS) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
